co_tick_timer: RTL and testbench
================================

CO_TICK_TIMER -- requirements
Module: co_tick_timer

Interface
REQ-001 SHALL have parameter W, default 8: width of limit and tick count.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port co  input  1  carry-out pulse from upstream 4-bit counter; one tick per high cycle.
REQ-005 SHALL have port start  input  1  request to arm a measurement; sampled only in IDLE.
REQ-006 SHALL have port limit  input  W  number of co ticks to collect; 0 means 2^W.
REQ-007 SHALL have port ack  input  1  consumer accepts done; sampled only in HOLD.
REQ-008 SHALL have port cnt_en  output  1  enable driven to the upstream counter's en input.
REQ-009 SHALL have port busy  output  1  high in COUNT and HOLD.
REQ-010 SHALL have port done  output  1  completion valid; high only in HOLD.
REQ-011 SHALL have port tick_cnt  output  W  co ticks collected in the current or last run.
REQ-012 SHALL have port overrun  output  1  sticky flag: co seen while in HOLD.

Function
REQ-013 SHALL implement FSM states IDLE, COUNT, HOLD; encoding is implementation-defined.
REQ-014 SHALL, in IDLE with start=1, register limit into an internal limit register, clear tick_cnt and overrun, and enter COUNT next cycle.
REQ-015 SHALL ignore start outside IDLE; limit changes after capture SHALL have no effect on the run.
REQ-016 SHALL drive cnt_en=1 exactly while in COUNT (registered state decode, no combinational path from inputs).
REQ-017 SHALL, in COUNT, increment tick_cnt by 1 (mod 2^W) on each cycle with co=1.
REQ-018 SHALL, in COUNT, enter HOLD on the cycle after the co that brings tick_cnt to the captured limit (for limit=0: tick_cnt wraps from 2^W-1 to 0).
REQ-019 SHALL ignore co in IDLE; tick_cnt holds its last value in IDLE and HOLD.
REQ-020 SHALL assert done in HOLD and hold it until ack=1; on ack=1 in HOLD, enter IDLE next cycle and deassert done.
REQ-021 SHALL set overrun when co=1 while in HOLD; overrun stays set until the next accepted start or reset.
REQ-022 SHALL, on start in IDLE coincident with ack or co, act only on start (ack and co are don't-care in IDLE).
REQ-023 SHALL, on ack and co in the same HOLD cycle, set overrun and return to IDLE.
REQ-024 SHALL give latency: co at cycle n that completes the count -> done=1 at cycle n+1.

Reset
REQ-025 SHALL, while rst=0, immediately force state=IDLE, tick_cnt=0, limit register=0, cnt_en=0, busy=0, done=0, overrun=0, regardless of clk.
REQ-026 SHALL abort any run in progress on reset assertion; no done is produced for an aborted run.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst returns to 1.

Structure
REQ-028 SHALL place the FSM state type and state constants in the shared package for the counter family.
REQ-029 SHALL be a single module; tick counter and FSM in one block, no sub-module required.
REQ-030 SHALL contain no latches; all registers use the same async active-low reset.

Verification
REQ-031 Bench SHALL cover nominal: start with limit=3, co pulses on cycles 2,5,9 -> tick_cnt=3, done=1 at cycle 10, cnt_en=0 from cycle 10.
REQ-032 Bench SHALL cover limit=0: 256 co pulses -> tick_cnt wraps to 0, done=1; no done at earlier tick counts.
REQ-033 Bench SHALL cover handshake: done held 5 cycles with ack=0 and co=1 in cycle 3 -> overrun=1, tick_cnt unchanged. Then ack=1 -> IDLE next cycle, overrun stays 1 until next start.
REQ-034 Bench SHALL cover ignored inputs: start during COUNT and co during IDLE -> no state or tick_cnt change. Changing limit from 4 to 9 mid-run -> done still after 4 ticks.
REQ-035 Bench SHALL cover reset mid-run: rst=0 between clk edges with tick_cnt=2 -> all outputs 0 before the next edge. A subsequent start with limit=1 plus one co -> done=1.
REQ-036 Bench SHALL cover simultaneous events: ack=1 and co=1 in the same HOLD cycle -> IDLE next cycle with overrun=1.

Source files
------------

// File: rtl/co_tick_timer_pkg.sv
// Shared types for the counter family: state encoding of the co tick timer FSM.
package co_tick_timer_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCount = 2'd1,
        StHold  = 2'd2
    } tick_state_e;

endpackage

// File: rtl/co_tick_timer.sv
// Collects a programmed number of carry-out ticks from an upstream counter and
// holds a completion flag until the consumer acknowledges it.
module co_tick_timer
    import co_tick_timer_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         co,
    input  logic         start,
    input  logic [W-1:0] limit,
    input  logic         ack,
    output logic         cnt_en,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] tick_cnt,
    output logic         overrun
);

    tick_state_e  state;
    logic [W-1:0] limit_q;
    logic [W-1:0] tick_cnt_inc;

    // Modular compare makes limit=0 complete on the wrap to 0, i.e. after 2^W ticks.
    assign tick_cnt_inc = tick_cnt + W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= StIdle;
            limit_q  <= '0;
            tick_cnt <= '0;
            overrun  <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        limit_q  <= limit;
                        tick_cnt <= '0;
                        overrun  <= 1'b0;
                        state    <= StCount;
                    end
                end
                StCount: begin
                    if (co) begin
                        tick_cnt <= tick_cnt_inc;
                        if (tick_cnt_inc == limit_q) begin
                            state <= StHold;
                        end
                    end
                end
                StHold: begin
                    if (co) begin
                        overrun <= 1'b1;
                    end
                    if (ack) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Pure decodes of the state register; no input reaches these outputs.
    assign cnt_en = (state == StCount);
    assign busy   = (state == StCount) || (state == StHold);
    assign done   = (state == StHold);

endmodule

// File: tb/tb_co_tick_timer.sv
// Scoreboard bench for co_tick_timer: directed scenarios plus random traffic
// checked against a run-level reference model.
module tb_co_tick_timer;

    localparam int W    = 8;
    localparam int Span = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         co = 1'b0;
    logic         start = 1'b0;
    logic         ack = 1'b0;
    logic [W-1:0] limit = '0;
    logic         cnt_en;
    logic         busy;
    logic         done;
    logic [W-1:0] tick_cnt;
    logic         overrun;

    co_tick_timer #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .co       (co),
        .start    (start),
        .limit    (limit),
        .ack      (ack),
        .cnt_en   (cnt_en),
        .busy     (busy),
        .done     (done),
        .tick_cnt (tick_cnt),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cnt_en;
        int busy;
        int done;
        int tick_cnt;
        int overrun;
    } exp_t;

    exp_t exp_q[$];
    int   done_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: a run is "collect target ticks", target = limit or 2^W for 0.
    bit m_run, m_hold, m_ovr;
    int m_ticks  = 0;
    int m_target = 0;

    function automatic void chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_step(input bit r, input bit s, input bit c, input bit a,
                                       input int l);
        exp_t e;
        if (!r) begin
            m_run   = 1'b0;
            m_hold  = 1'b0;
            m_ovr   = 1'b0;
            m_ticks = 0;
        end else if (m_hold) begin
            if (c) m_ovr = 1'b1;
            if (a) m_hold = 1'b0;
        end else if (m_run) begin
            if (c) begin
                m_ticks++;
                if (m_ticks == m_target) begin
                    m_run  = 1'b0;
                    m_hold = 1'b1;
                    done_q.push_back(m_ticks % Span);
                end
            end
        end else if (s) begin
            m_target = (l == 0) ? Span : l;
            m_ticks  = 0;
            m_ovr    = 1'b0;
            m_run    = 1'b1;
        end
        e.cnt_en   = int'(m_run);
        e.busy     = int'(m_run || m_hold);
        e.done     = int'(m_hold);
        e.tick_cnt = m_ticks % Span;
        e.overrun  = int'(m_ovr);
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit r, input bit s, input bit c, input bit a, input int l);
        @(negedge clk);
        rst   = r;
        start = s;
        co    = c;
        ack   = a;
        limit = W'(l);
        model_step(r, s, c, a, l);
    endtask

    // Reset asserted between edges must clear outputs before the next edge.
    task automatic reset_midcycle();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_cnt_en", int'(cnt_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_tick_cnt", int'(tick_cnt), 0);
        chk("rst_overrun", int'(overrun), 0);
        model_step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Monitor: compares after every edge, and matches each done rising edge to a completion.
    initial begin
        exp_t e;
        bit   prev_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cnt_en", int'(cnt_en), e.cnt_en);
                chk("busy", int'(busy), e.busy);
                chk("done", int'(done), e.done);
                chk("tick_cnt", int'(tick_cnt), e.tick_cnt);
                chk("overrun", int'(overrun), e.overrun);
            end
            if (done && !prev_done) begin
                chk("done_pending", int'(done_q.size() > 0), 1);
                if (done_q.size() > 0) begin
                    chk("done_tick_cnt", int'(tick_cnt), done_q.pop_front());
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Nominal: limit=3, co on cycles 2,5,9 -> done at cycle 10
        step(1, 1, 0, 0, 3);
        for (int c = 1; c <= 9; c++) step(1, 0, (c == 2 || c == 5 || c == 9), 0, 3);

        // Handshake: done held 5 cycles, co in the third -> overrun, count unchanged
        for (int i = 1; i <= 5; i++) step(1, 0, (i == 3), 0, 3);
        step(1, 0, 0, 1, 3);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 3);

        // Ignored start during COUNT, limit 4 -> 9 mid-run still completes at 4
        step(1, 1, 0, 0, 4);
        for (int i = 0; i < 8; i++) step(1, 1, (i % 2 == 1), 0, 9);
        step(1, 0, 0, 0, 9);
        step(1, 0, 0, 1, 9);

        // Simultaneous ack and co in HOLD
        step(1, 1, 0, 0, 1);
        step(1, 0, 1, 0, 1);
        step(1, 0, 1, 1, 1);
        step(1, 0, 0, 0, 1);

        // limit=0 collects 2^W ticks and wraps to 0
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < Span; i++) step(1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);

        // Reset mid-run with tick_cnt=2, then a fresh limit=1 run
        step(1, 1, 0, 0, 5);
        step(1, 0, 1, 0, 5);
        step(1, 0, 1, 0, 5);
        reset_midcycle();
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        step(1, 0, 1, 0, 1);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 1, 1);

        // Random traffic
        repeat (500) begin
            step($urandom_range(0, 149) != 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 6)));
        end

        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
